// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART deserializer and the CPU bus: edge-detected pushes,
// memory-mapped pop/status/control at 252..255, and an acknowledged interrupt FSM.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int INT_LEVEL = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic [7:0]    access_addr,
    input  logic          reg_w_en,
    input  logic          reg_r_en,
    input  logic [7:0]    wr_data,
    output logic [7:0]    rd_data,
    output logic          int_req,
    output logic          overflow,
    output logic [AW:0]   count
);
    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_PEND  = 2'd1,
        ST_WAIT  = 2'd2
    } int_st_e;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] INT_LVL  = (AW+1)'(INT_LEVEL);

    logic [7:0]    mem_q [DEPTH];
    logic          rx_q, rx_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          rearm_q, rearm_d;
    int_st_e       st_q, st_d;

    logic empty, full, push_req, pop_req, flush, clr_ovf, ack;
    logic do_push, do_pop, ovf_set;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_LVL);
        push_req = rx_valid && !rx_q && !reset;
        pop_req  = reg_r_en && (access_addr == 8'd253) && !empty;
        flush    = reg_w_en && (access_addr == 8'd255) && wr_data[0];
        clr_ovf  = reg_w_en && (access_addr == 8'd255) && wr_data[1];
        ack      = reg_w_en && (access_addr == 8'd252);
        do_pop   = pop_req && !flush;
        do_push  = push_req && !flush && (!full || pop_req);
        ovf_set  = push_req && !flush && full && !pop_req;
    end

    // While reset is held the edge register tracks rx_valid, so a level that is
    // already high when reset releases is not mistaken for a new byte.
    always_comb begin
        rx_d    = rx_valid;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
        if (ovf_set)      ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    // rearm remembers a push that coincided with an ack so WAIT re-raises next cycle.
    always_comb begin
        st_d    = st_q;
        rearm_d = 1'b0;
        if (flush) begin
            st_d = ST_ARMED;
        end else begin
            case (st_q)
                ST_ARMED: if (count_q >= INT_LVL) st_d = ST_PEND;
                ST_PEND: if (ack) begin
                    st_d    = ST_WAIT;
                    rearm_d = do_push;
                end
                ST_WAIT: begin
                    if (do_push || rearm_q)   st_d = ST_PEND;
                    else if (count_q < INT_LVL) st_d = ST_ARMED;
                end
                default: st_d = ST_ARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q    <= rx_valid;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            rearm_q <= 1'b0;
            st_q    <= ST_ARMED;
        end else begin
            rx_q    <= rx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            rearm_q <= rearm_d;
            st_q    <= st_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= rx_data;
    end

    always_comb begin
        int_req  = (st_q == ST_PEND);
        overflow = ovf_q;
        count    = count_q;
        rd_data  = 8'h00;
        case (access_addr)
            8'd253:  rd_data = empty ? 8'h00 : mem_q[rptr_q];
            8'd254:  rd_data = {4'b0, int_req, ovf_q, full, !empty};
            default: rd_data = 8'h00;
        endcase
    end
endmodule
